noc_input_buffer: RTL and testbench

NOC_INPUT_BUFFER -- requirements
Module: noc_input_buffer

---
 rtl/noc_input_buffer.sv | 130 +++++++++++++
 tb/tb_noc_input_buffer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_buffer.sv
// NoC router input port: flit FIFO plus a packet FSM that requests the crossbar for
// well-formed packets and silently drains malformed ones. INBUF_DROP_CNT_EN adds drop_cnt.
module noc_input_buffer #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned FLIT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              grant,
  output logic              req,
  output logic [2:0]        flit_id,
  output logic [11:0]       length,
  output logic [FLIT_W-1:0] flit_out,
`ifdef INBUF_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  output logic              valid_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
  localparam logic [2:0] IdHead = 3'b001;
  localparam logic [2:0] IdTail = 3'b100;

  typedef enum logic [1:0] {StIdle, StActive, StDrop} state_e;

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  state_e            state_q, state_d;
  logic [11:0]       len_q, len_d;

  logic              empty, full, wr_en, pop;
  logic              head_is_hdr, head_is_tail;
  logic [FLIT_W-1:0] head;
  logic [2:0]        head_id;

  always_comb begin
    empty        = (count_q == '0);
    full         = (count_q == FullCnt);
    head         = mem_q[rd_ptr_q];
    head_id      = empty ? 3'b000 : head[FLIT_W-1 -: 3];
    head_is_hdr  = (head_id == IdHead);
    head_is_tail = (head_id == IdTail);
    ready_out    = !full;
    // No bypass: a flit written this cycle reaches the head no earlier than next cycle.
    wr_en        = valid_in && !full && !rst;
    flit_id      = head_id;
    flit_out     = empty ? '0 : head;
    length       = head_is_hdr ? head[11:0] : len_q;
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req       = 1'b0;
    valid_out = 1'b0;
    pop       = 1'b0;
    case (state_q)
      StIdle: begin
        req = head_is_hdr;
        if (head_is_hdr) begin
          state_d = StActive;
          len_d   = head[11:0];
        end else if (!empty) begin
          state_d = StDrop;
        end
      end
      StActive: begin
        req       = 1'b1;
        valid_out = grant && !empty;
        pop       = valid_out;
        if (pop && head_is_tail) state_d = StIdle;
      end
      StDrop: begin
        // Discard until the tail of the malformed packet, independent of the arbiter.
        pop = !empty;
        if (pop && head_is_tail) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q + CntW'(wr_en) - CntW'(pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= flit_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= StIdle;
      len_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      len_q    <= len_d;
    end
  end

`ifdef INBUF_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (state_q == StDrop && pop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    drop_cnt = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end
`endif

endmodule

// File: tb/tb_noc_input_buffer.sv
// Directed bench for noc_input_buffer: a queue-based packet model is compared every cycle,
// and literal expectations at key points pin the model itself.
module tb_noc_input_buffer;
  localparam int DEPTH  = 8;
  localparam int FLIT_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [FLIT_W-1:0] flit_in = '0;
  logic              valid_in = 1'b0;
  logic              grant = 1'b0;
  logic              ready_out, req, valid_out;
  logic [2:0]        flit_id;
  logic [11:0]       length;
  logic [FLIT_W-1:0] flit_out;
`ifdef INBUF_DROP_CNT_EN
  logic [7:0]        drop_cnt;
`endif

  noc_input_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .grant     (grant),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .flit_out  (flit_out),
`ifdef INBUF_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int p0, p1;
  bit model_on = 1'b0;

  // Model: buffered flits in arrival order plus what the port is doing with them.
  localparam int MIdle = 0, MPkt = 1, MDrop = 2;
  logic [31:0] mq[$];
  int          mode = MIdle;
  logic [11:0] m_len = '0;
  int          m_drop = 0;

  function automatic logic [31:0] hdr(input int l);
    return {3'b001, 17'h00A5A, 12'(l)};
  endfunction
  function automatic logic [31:0] body(input int n);
    return {3'b010, 29'(n)};
  endfunction
  function automatic logic [31:0] tail(input int n);
    return {3'b100, 29'(n)};
  endfunction
  function automatic logic [31:0] bad(input int n);
    return {3'b101, 29'(n)};
  endfunction

  function automatic logic [31:0] m_head();
    return (mq.size() > 0) ? mq[0] : 32'h0;
  endfunction

  function automatic bit m_fwd();
    return (mode == MPkt) && grant && (mq.size() > 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the inputs that were applied.
  task automatic model_update();
    logic [31:0] h;
    bit nonempty, pop, can_wr;
    if (rst) begin
      mq.delete();
      mode     = MIdle;
      m_len    = '0;
      m_drop   = 0;
      model_on = 1'b1;
    end else if (model_on) begin
      nonempty = mq.size() > 0;
      h        = m_head();
      can_wr   = valid_in && (mq.size() < DEPTH);
      pop      = m_fwd() || (mode == MDrop && nonempty);
      if (mode == MIdle && nonempty) begin
        if (h[31:29] == 3'b001) begin
          mode  = MPkt;
          m_len = h[11:0];
        end else begin
          mode = MDrop;
        end
      end else if (pop) begin
        if (mode == MDrop && m_drop < 255) m_drop++;
        if (h[31:29] == 3'b100) mode = MIdle;
        void'(mq.pop_front());
      end
      if (can_wr) mq.push_back(flit_in);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] f, input logic g);
    valid_in = v;
    flit_in  = f;
    grant    = g;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin : compare
    logic [31:0] h;
    forever begin
      @(negedge clk);
      if (model_on && !rst) begin
        h = m_head();
        check("ready_out", {31'b0, ready_out}, {31'b0, mq.size() < DEPTH});
        check("flit_id", {29'b0, flit_id}, {29'b0, h[31:29]});
        check("req", {31'b0, req},
              {31'b0, mode == MPkt || (mode == MIdle && h[31:29] == 3'b001)});
        check("length", {20'b0, length}, {20'b0, (h[31:29] == 3'b001) ? h[11:0] : m_len});
        check("valid_out", {31'b0, valid_out}, {31'b0, m_fwd()});
        if (mq.size() > 0) check("flit_out", flit_out, h);
`ifdef INBUF_DROP_CNT_EN
        check("drop_cnt", {24'b0, drop_cnt}, 32'(m_drop));
`endif
        if (valid_out) pops++;
      end
    end
  end

  initial begin
    // Reset with a flit offered: it must not be written.
    rst = 1'b1;
    repeat (3) step(1'b1, hdr(7), 1'b0);
    rst = 1'b0;
    valid_in = 1'b0;
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_req", {31'b0, req}, 32'd0);
    check("rst_flit_id", {29'b0, flit_id}, 32'd0);
    check("rst_valid_out", {31'b0, valid_out}, 32'd0);

    // Basic packet: header(len=5), 2 bodies, tail; grant from the third cycle.
    step(1'b1, hdr(5), 1'b0);
    check("pkt_req_hdr", {31'b0, req}, 32'd1);
    check("pkt_len", {20'b0, length}, 32'd5);
    step(1'b1, body(1), 1'b0);
    p0 = pops;
    step(1'b1, body(2), 1'b1);
    step(1'b1, tail(3), 1'b1);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("pkt_pops", 32'(pops - p0), 32'd4);
    check("pkt_idle_req", {31'b0, req}, 32'd0);
    check("pkt_empty_id", {29'b0, flit_id}, 32'd0);

    // Fill to DEPTH with no grant; the ninth offer is ignored.
    step(1'b1, hdr(3), 1'b0);
    for (int i = 1; i <= 6; i++) step(1'b1, body(i), 1'b0);
    step(1'b1, tail(7), 1'b0);
    check("full_ready", {31'b0, ready_out}, 32'd0);
    step(1'b1, body(99), 1'b0);
    check("full_ready_hold", {31'b0, ready_out}, 32'd0);
    check("full_head_hdr", {29'b0, flit_id}, 32'd1);

    // Pop while full with a write offered: one pop only, order preserved.
    p0 = pops;
    step(1'b1, body(77), 1'b1);
    check("full_pop_ready", {31'b0, ready_out}, 32'd1);
    check("full_pop_head", {29'b0, flit_id}, 32'd2);
    repeat (7) step(1'b0, 32'h0, 1'b1);
    check("drain_pops", 32'(pops - p0), 32'd8);
    check("drain_req", {31'b0, req}, 32'd0);

    // Orphan body and tail are dropped; the following header is requested.
    step(1'b1, body(5), 1'b0);
    step(1'b1, tail(6), 1'b0);
    step(1'b1, hdr(9), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("drop_req_hdr", {31'b0, req}, 32'd1);
    check("drop_len", {20'b0, length}, 32'd9);
`ifdef INBUF_DROP_CNT_EN
    check("drop_cnt_2", {24'b0, drop_cnt}, 32'd2);
`endif

    // Grant withdrawn mid-packet for three cycles.
    step(1'b0, 32'h0, 1'b0);
    p0 = pops;
    step(1'b1, body(1), 1'b1);
    step(1'b1, body(2), 1'b1);
    p1 = pops;
    check("mid_pops_before", 32'(p1 - p0), 32'd2);
    step(1'b1, tail(3), 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    check("mid_no_pops", 32'(pops - p1), 32'd0);
    check("mid_req", {31'b0, req}, 32'd1);
    step(1'b0, 32'h0, 1'b1);
    check("mid_resume_pop", 32'(pops - p1), 32'd1);
    check("mid_resume_head", {29'b0, flit_id}, 32'd4);
    step(1'b0, 32'h0, 1'b1);
    check("mid_end_req", {31'b0, req}, 32'd0);

    // Reset after two of four flits popped; a flit offered during reset is discarded.
    step(1'b1, hdr(4), 1'b0);
    step(1'b1, body(1), 1'b0);
    step(1'b1, body(2), 1'b0);
    step(1'b1, tail(3), 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    rst = 1'b1;
    step(1'b1, hdr(11), 1'b0);
    rst = 1'b0;
    valid_in = 1'b0;
    check("mrst_ready", {31'b0, ready_out}, 32'd1);
    check("mrst_req", {31'b0, req}, 32'd0);
    check("mrst_flit_id", {29'b0, flit_id}, 32'd0);
    step(1'b1, hdr(2), 1'b0);
    check("mrst_hdr_req", {31'b0, req}, 32'd1);
    check("mrst_hdr_len", {20'b0, length}, 32'd2);
    step(1'b1, tail(3), 1'b0);
    p0 = pops;
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    check("mrst_pops", 32'(pops - p0), 32'd2);
    check("mrst_idle_req", {31'b0, req}, 32'd0);

    // Combined header/tail code is illegal and dropped up to the next tail.
    step(1'b1, bad(1), 1'b0);
    step(1'b1, tail(2), 1'b0);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    check("bad_req", {31'b0, req}, 32'd0);
    check("bad_empty_id", {29'b0, flit_id}, 32'd0);
`ifdef INBUF_DROP_CNT_EN
    check("bad_drop_cnt", {24'b0, drop_cnt}, 32'd2);
`endif

    repeat (2) step(1'b0, 32'h0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
